code_mem_arbiter: RTL and testbench

Shares the single-port, word-organised code memory between two requesters: the CPU instruction-fetch port (F) and a debug/loader port (D) that can read and write words. Each cycle it grants at most one request with round-robin priority on conflict. It rejects misaligned or out-of-range addresses with an error response and no memory access. It returns each response on a fixed one-cycle latency path matching the memory's registered read.

---
 rtl/code_mem_arbiter.sv | 109 ++++++++++
 tb/tb_code_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_mem_arbiter.sv
// Round-robin arbiter sharing a single-port word memory between an instruction fetch port
// and a debug/loader port. Illegal addresses are granted but answered with an error response.
module code_mem_arbiter #(
  parameter int unsigned SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  output logic        f_err_o,
  output logic [31:0] f_inst_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] SizeBytes = 32'(SIZE);

  logic        f_legal_c;
  logic        d_legal_c;
  logic        sel_legal_c;
  logic [29:0] sel_word_c;
  logic [31:0] rsp_data_c;

  // rr_q = 1 means D was granted most recently, so F wins the next conflict
  logic rr_q, rr_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_d_q, rsp_d_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_rd_q, rsp_rd_d;

  assign f_legal_c = (f_addr_i[1:0] == 2'b00) && (f_addr_i < SizeBytes);
  assign d_legal_c = (d_addr_i[1:0] == 2'b00) && (d_addr_i < SizeBytes);

  // Grant selection; nothing is granted while reset is asserted
  always_comb begin
    f_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    if (!rst_i) begin
      if (f_req_i && (!d_req_i || rr_q)) begin
        f_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end
    end
  end

  assign sel_legal_c = (f_gnt_o && f_legal_c) || (d_gnt_o && d_legal_c);
  assign sel_word_c  = f_gnt_o ? f_addr_i[31:2] : d_addr_i[31:2];

  assign mem_en_o    = sel_legal_c;
  assign mem_we_o    = d_gnt_o && d_legal_c && d_we_i;
  assign mem_addr_o  = sel_legal_c ? sel_word_c : 30'h0;
  assign mem_wdata_o = sel_legal_c ? d_wdata_i : 32'h0;

  // Response bookkeeping captured on every grant
  always_comb begin
    rr_d        = rr_q;
    rsp_valid_d = f_gnt_o || d_gnt_o;
    rsp_d_d     = rsp_d_q;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    if (f_gnt_o || d_gnt_o) begin
      rr_d      = d_gnt_o;
      rsp_d_d   = d_gnt_o;
      rsp_err_d = !sel_legal_c;
      rsp_rd_d  = f_gnt_o || !d_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_d_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_d_q     <= rsp_d_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Memory read data is already registered, so it is steered straight to the owner
  assign rsp_data_c = (rsp_valid_q && !rsp_err_q && rsp_rd_q) ? mem_rdata_i : 32'h0;

  assign f_rvalid_o = rsp_valid_q && !rsp_d_q;
  assign f_err_o    = f_rvalid_o && rsp_err_q;
  assign f_inst_o   = f_rvalid_o ? rsp_data_c : 32'h0;
  assign d_ack_o    = rsp_valid_q && rsp_d_q;
  assign d_err_o    = d_ack_o && rsp_err_q;
  assign d_rdata_o  = d_ack_o ? rsp_data_c : 32'h0;

endmodule

// File: tb/tb_code_mem_arbiter.sv
// Bench for code_mem_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model holding its own copy of the memory contents.
module tb_code_mem_arbiter;

  localparam int unsigned SIZE  = 1024;
  localparam int unsigned WORDS = SIZE / 4;

  typedef struct {
    bit          fr;
    logic [31:0] fa;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dd;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_inst;
  logic        d_req, d_we, d_gnt, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  code_mem_arbiter #(.SIZE(SIZE)) dut (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt),
    .f_rvalid_o(f_rvalid), .f_err_o(f_err), .f_inst_o(f_inst),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_ack_o(d_ack), .d_err_o(d_err), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read, preloaded with word i = i + 0x100
  logic [31:0] mem [WORDS];
  logic        do_load;
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < int'(WORDS); i++) mem[i] <= 32'(i) + 32'h100;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  logic [65:0] obs_g;
  logic [67:0] obs_r;
  assign obs_g = {f_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata};
  assign obs_r = {f_rvalid, f_err, f_inst, d_ack, d_err, d_rdata};

  int total = 0;
  int bad   = 0;

  // Reference model state: who was served last, memory image, and the pending reply
  bit          last_was_d;
  logic [31:0] ref_mem [WORDS];
  bit          p_valid, p_d, p_err;
  logic [31:0] p_data;
  bit          n_valid, n_d, n_err, n_wr;
  logic [31:0] n_data, n_wdata;
  int          n_widx;
  logic [65:0] exp_g;
  logic [67:0] exp_r;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < SIZE);
  endfunction

  task automatic model_reset();
    last_was_d = 1'b1;
    p_valid = 0; p_d = 0; p_err = 0; p_data = '0;
  endtask

  task automatic model_eval();
    bit gf, gd, lg, rd;
    logic [31:0] a;
    int w;
    gf = 0; gd = 0;
    if (!rst) begin
      if (f_req && d_req) begin
        if (last_was_d) gf = 1; else gd = 1;
      end else if (f_req) gf = 1;
      else if (d_req) gd = 1;
    end
    a  = gf ? f_addr : d_addr;
    lg = (gf || gd) && legal(a);
    w  = int'(a / 4);
    rd = gf || !d_we;
    exp_g = {gf, gd, lg, lg && gd && d_we, lg ? 30'(w) : 30'h0, lg ? d_wdata : 32'h0};
    exp_r = {p_valid && !p_d, p_valid && !p_d && p_err, (p_valid && !p_d) ? p_data : 32'h0,
             p_valid && p_d, p_valid && p_d && p_err, (p_valid && p_d) ? p_data : 32'h0};
    n_valid = gf || gd;
    n_d     = gd;
    n_err   = !lg;
    n_data  = (lg && rd) ? ref_mem[w] : 32'h0;
    n_wr    = lg && gd && d_we;
    n_widx  = w;
    n_wdata = d_wdata;
  endtask

  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else begin
      p_valid = n_valid; p_d = n_d; p_err = n_err; p_data = n_data;
      if (n_valid) last_was_d = n_d;
      if (n_wr) ref_mem[n_widx] = n_wdata;
    end
  endtask

  task automatic apply(input stim_t s);
    f_req = s.fr; f_addr = s.fa;
    d_req = s.dr; d_we = s.dw; d_addr = s.da; d_wdata = s.dd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; do_load = 1'b1;
    apply('{1, 32'h0, 1, 0, 32'h4, 32'h0});
    model_reset();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'(i) + 32'h100;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL reset_gnt: got %h want %h", obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL reset_rsp: got %h want %h", obs_r, exp_r);
      end
      tick();
    end
    do_load = 1'b0;
    rst = 1'b0;
    apply('{0, 32'h0, 0, 0, 32'h0, 32'h0});
  endtask

  task automatic test_fetch_seq();
    stim_t tbl [5] = '{'{1, 32'h0, 0, 0, 32'h0, 32'h0}, '{1, 32'h4, 0, 0, 32'h0, 32'h0},
                       '{1, 32'h8, 0, 0, 32'h0, 32'h0}, '{0, 32'h0, 0, 0, 32'h0, 32'h0},
                       '{0, 32'h0, 0, 0, 32'h0, 32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL fetch_seq_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL fetch_seq_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) apply('{1, 32'h10, 1, 0, 32'h20, 32'h0});
      else       apply('{0, 32'h0, 0, 0, 32'h0, 32'h0});
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL conflict_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL conflict_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_write_then_fetch();
    stim_t tbl [4] = '{'{0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF}, '{1, 32'h40, 0, 0, 32'h0, 32'h0},
                       '{0, 32'h0, 0, 0, 32'h0, 32'h0}, '{0, 32'h0, 0, 0, 32'h0, 32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL wr_fetch_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL wr_fetch_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_errors();
    stim_t tbl [8] = '{'{1, 32'h6, 1, 0, 32'h400, 32'h0},
                       '{0, 32'h0, 1, 0, 32'h400, 32'h0},
                       '{0, 32'h0, 1, 0, 32'h3FC, 32'h0},
                       '{1, 32'hFFFFFFFC, 0, 0, 32'h0, 32'h0},
                       '{0, 32'h0, 1, 1, 32'h40000000, 32'h12345678},
                       '{1, 32'h1000, 1, 0, 32'h0, 32'h0},
                       '{0, 32'h0, 1, 0, 32'h0, 32'h0},
                       '{0, 32'h0, 0, 0, 32'h0, 32'h0}};
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL errors_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL errors_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    apply('{0, 32'h0, 1, 0, 32'h20, 32'h0});
    #1 model_eval();
    total++;
    if (obs_g !== exp_g) begin
      bad++; $display("FAIL inflight_gnt: got %h want %h", obs_g, exp_g);
    end
    #1 rst = 1'b1;
    #1 model_reset();
    model_eval();
    total++;
    if (obs_g !== exp_g) begin
      bad++; $display("FAIL inflight_rst_gnt: got %h want %h", obs_g, exp_g);
    end
    tick();
    #1 model_eval();
    total++;
    if (obs_r !== exp_r) begin
      bad++; $display("FAIL inflight_ack: got %h want %h", obs_r, exp_r);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) apply('{1, 32'h10, 1, 0, 32'h20, 32'h0});
      else        apply('{0, 32'h0, 0, 0, 32'h0, 32'h0});
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL post_rst_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL post_rst_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) apply('{1, 32'h8, 1, 0, 32'hC, 32'h0});
      else        apply('{0, 32'h0, 0, 0, 32'h0, 32'h0});
      #1 model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL idle_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL idle_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [4] = '{32'h3FC, 32'h400, 32'hFFFFFFFC, 32'h404};
    case ($urandom_range(0, 3))
      0, 1: return 32'($urandom_range(0, WORDS - 1)) << 2;
      2:    return $urandom();
      default: return edges[$urandom_range(0, 3)];
    endcase
  endfunction

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.fr = ($urandom_range(0, 2) != 0);
      s.fa = rand_addr();
      s.dr = ($urandom_range(0, 2) != 0);
      s.dw = $urandom_range(0, 1) == 1;
      s.da = rand_addr();
      s.dd = $urandom();
      apply(s);
      rst = ($urandom_range(0, 59) == 0);
      #1;
      if (rst) model_reset();
      model_eval();
      total++;
      if (obs_g !== exp_g) begin
        bad++; $display("FAIL random_gnt[%0d]: got %h want %h", i, obs_g, exp_g);
      end
      total++;
      if (obs_r !== exp_r) begin
        bad++; $display("FAIL random_rsp[%0d]: got %h want %h", i, obs_r, exp_r);
      end
      tick();
    end
    rst = 1'b0;
    apply('{0, 32'h0, 0, 0, 32'h0, 32'h0});
    #1 model_eval();
    total++;
    if (obs_r !== exp_r) begin
      bad++; $display("FAIL random_tail_rsp: got %h want %h", obs_r, exp_r);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch_seq();
    test_conflict();
    test_write_then_fetch();
    test_errors();
    test_reset_inflight();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
